bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter.sv | 102 ++++++++++
 tb/tb_bus_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Bus arbiter sharing the system bus between the CPU, graphics DMA and audio DMA.
// Ownership is registered; grants and bus muxes decode only from the registered owner.
module bus_arbiter #(
  parameter int unsigned BURST_MAX = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  input  logic        gdma_req,
  input  logic [13:0] gdma_addr,
  input  logic [7:0]  gdma_dout,
  input  logic        gdma_we,
  output logic        gdma_gnt,
  input  logic        lcd_busy,
  input  logic        adma_req,
  input  logic [15:0] adma_addr,
  output logic        adma_ack,
  output logic [7:0]  adma_data,
  input  logic [7:0]  bus_din,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_we,
  output logic [1:0]  owner
);

  localparam int unsigned     CntW      = $clog2(BURST_MAX + 1);
  localparam logic [CntW-1:0] BurstMaxC = CntW'(BURST_MAX);

  localparam logic [1:0] OwnCpu  = 2'd0;
  localparam logic [1:0] OwnGdma = 2'd1;
  localparam logic [1:0] OwnAdma = 2'd2;

  logic [1:0]      owner_q, owner_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            adma_ack_q;
  logic [7:0]      adma_data_q;
  logic            adma_elig, gdma_elig;

  // burst_cnt_d already includes the current cycle, so the limit yields exactly
  // BURST_MAX back-to-back GDMA cycles before the forced CPU cycle.
  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (owner_q == OwnGdma) begin
      if (burst_cnt_q != BurstMaxC) burst_cnt_d = burst_cnt_q + CntW'(1);
    end else if (owner_q != OwnAdma) begin
      burst_cnt_d = '0;
    end
  end

  assign adma_elig = adma_req & (owner_q != OwnAdma);
  assign gdma_elig = gdma_req & ~lcd_busy & (burst_cnt_d < BurstMaxC);

  always_comb begin
    owner_d = OwnCpu;
    if (adma_elig)      owner_d = OwnAdma;
    else if (gdma_elig) owner_d = OwnGdma;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      owner_q     <= OwnCpu;
      burst_cnt_q <= '0;
      adma_ack_q  <= 1'b0;
      adma_data_q <= 8'h00;
    end else begin
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
      adma_ack_q  <= (owner_q == OwnAdma);
      if (adma_ack_q) adma_data_q <= bus_din;
    end
  end

  assign owner    = owner_q;
  assign gdma_gnt = (owner_q == OwnGdma);
  assign cpu_rdy  = (owner_q != OwnGdma) & (owner_q != OwnAdma);
  assign adma_ack = adma_ack_q;
  // Read data arrives one cycle late, so the ack cycle passes it straight through.
  assign adma_data = adma_ack_q ? bus_din : adma_data_q;

  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_we   = cpu_we;
    case (owner_q)
      OwnGdma: begin
        bus_addr = {2'b00, gdma_addr};
        bus_dout = gdma_dout;
        bus_we   = gdma_we;
      end
      OwnAdma: begin
        bus_addr = adma_addr;
        bus_dout = 8'h00;
        bus_we   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: directed scenarios followed by random traffic,
// checked against a rule-level model of bus ownership.
module tb_bus_arbiter;

  localparam int unsigned BurstMax = 16;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_we;
  logic        cpu_rdy;
  logic        gdma_req;
  logic [13:0] gdma_addr;
  logic [7:0]  gdma_dout;
  logic        gdma_we;
  logic        gdma_gnt;
  logic        lcd_busy;
  logic        adma_req;
  logic [15:0] adma_addr;
  logic        adma_ack;
  logic [7:0]  adma_data;
  logic [7:0]  bus_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_we;
  logic [1:0]  owner;

  bus_arbiter #(.BURST_MAX(BurstMax)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_we    (cpu_we),
    .cpu_rdy   (cpu_rdy),
    .gdma_req  (gdma_req),
    .gdma_addr (gdma_addr),
    .gdma_dout (gdma_dout),
    .gdma_we   (gdma_we),
    .gdma_gnt  (gdma_gnt),
    .lcd_busy  (lcd_busy),
    .adma_req  (adma_req),
    .adma_addr (adma_addr),
    .adma_ack  (adma_ack),
    .adma_data (adma_data),
    .bus_din   (bus_din),
    .bus_addr  (bus_addr),
    .bus_dout  (bus_dout),
    .bus_we    (bus_we),
    .owner     (owner)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int         cyc;
    logic [1:0] own;
    logic       ack;
    logic       clr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Model: owner of the current cycle and number of GDMA cycles since the last CPU cycle.
  logic [1:0] m_own    = 2'd0;
  int         m_streak = 0;

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, want);
    end
  endtask

  // Predict the next cycle from the inputs about to be sampled, then advance one clock.
  task automatic step();
    logic [1:0] nxt;
    logic       ack;
    if (!reset) begin
      nxt      = 2'd0;
      ack      = 1'b0;
      m_streak = 0;
    end else begin
      ack = (m_own == 2'd2);
      if (adma_req && m_own != 2'd2)                           nxt = 2'd2;
      else if (gdma_req && !lcd_busy && m_streak < BurstMax) nxt = 2'd1;
      else                                                     nxt = 2'd0;
      if (nxt == 2'd1)      m_streak++;
      else if (nxt == 2'd0) m_streak = 0;
    end
    m_own = nxt;
    exp_q.push_back('{cyc: cyc + 1, own: nxt, ack: ack, clr: !reset});
    @(posedge clk_sys);
    #1;
  endtask

  task automatic rnd_data();
    cpu_addr  = 16'($urandom);
    cpu_dout  = 8'($urandom);
    cpu_we    = 1'($urandom);
    gdma_addr = 14'($urandom);
    gdma_dout = 8'($urandom);
    gdma_we   = 1'($urandom);
    adma_addr = 16'($urandom);
    bus_din   = 8'($urandom);
  endtask

  // Monitor
  exp_t        e;
  logic [15:0] ea;
  logic [7:0]  ed;
  logic        ew;
  logic [7:0]  last_data = 8'h00;

  initial forever begin
    @(negedge clk_sys);
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      e = exp_q.pop_front();
      if (e.clr) last_data = 8'h00;
      case (e.own)
        2'd1:    begin ea = {2'b00, gdma_addr}; ed = gdma_dout; ew = gdma_we; end
        2'd2:    begin ea = adma_addr;          ed = 8'h00;     ew = 1'b0;    end
        default: begin ea = cpu_addr;           ed = cpu_dout;  ew = cpu_we;  end
      endcase
      chk("owner",    16'(owner),    16'(e.own));
      chk("cpu_rdy",  16'(cpu_rdy),  16'(e.own == 2'd0));
      chk("gdma_gnt", 16'(gdma_gnt), 16'(e.own == 2'd1));
      chk("adma_ack", 16'(adma_ack), 16'(e.ack));
      chk("bus_addr", bus_addr,      ea);
      chk("bus_dout", 16'(bus_dout), 16'(ed));
      chk("bus_we",   16'(bus_we),   16'(ew));
      if (e.ack) last_data = bus_din;
      chk("adma_data", 16'(adma_data), 16'(last_data));
    end
  end

  initial begin
    reset    = 1'b0;
    gdma_req = 1'b0;
    lcd_busy = 1'b0;
    adma_req = 1'b0;
    rnd_data();
    @(posedge clk_sys);
    #1;
    repeat (3) step();
    reset = 1'b1;

    // Idle CPU traffic at a fixed address
    cpu_addr = 16'h2026;
    cpu_we   = 1'b1;
    repeat (6) step();

    // Long GDMA burst: forced CPU cycle every BurstMax grants
    gdma_req = 1'b1;
    repeat (40) begin
      rnd_data();
      step();
    end
    gdma_req = 1'b0;
    repeat (2) step();

    // Single ADMA read returning 8'h5A
    adma_addr = 16'h8123;
    adma_req  = 1'b1;
    step();
    adma_req = 1'b0;
    step();
    bus_din = 8'h5A;
    step();
    repeat (3) begin
      rnd_data();
      step();
    end

    // Simultaneous ADMA and GDMA requests
    adma_req = 1'b1;
    gdma_req = 1'b1;
    step();
    adma_req = 1'b0;
    repeat (8) begin
      rnd_data();
      step();
    end

    // LCD fetch mid-burst
    lcd_busy = 1'b1;
    repeat (5) step();
    lcd_busy = 1'b0;
    repeat (10) step();

    // Reset mid-burst, then reset during an ADMA cycle
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (4) step();
    gdma_req = 1'b0;
    adma_req = 1'b1;
    step();
    adma_req = 1'b0;
    reset    = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();

    // Random traffic
    repeat (3000) begin
      rnd_data();
      if ($urandom_range(7) == 0) gdma_req = ~gdma_req;
      if ($urandom_range(9) == 0) lcd_busy = ~lcd_busy;
      adma_req = ($urandom_range(3) == 0);
      reset    = ($urandom_range(99) != 0);
      step();
    end

    repeat (2) @(negedge clk_sys);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0 pending expectations", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
